// File: rtl/mem_req_arbiter_pkg.sv
// Shared widths, state encodings and port IDs for the two-port memory line-request arbiter.
package mem_req_arbiter_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_LINE_W = 128;
  localparam int MEM_MASK_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_PORT_I = 1'b0,
    ARB_PORT_D = 1'b1
  } arb_port_t;

  // Memory works on whole lines, so the byte offset within a line is dropped.
  function automatic logic [MEM_ADDR_W-1:0] line_align(input logic [MEM_ADDR_W-1:0] addr);
    return addr & 16'hFFF0;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_pick.sv
// Combinational two-way pick between the instruction and data request ports.
module mem_arb_pick
  import mem_req_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_port
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_port  = ARB_PORT_I;
    if (d_req && !i_req) begin
      grant_port = ARB_PORT_D;
    end else if (d_req && i_req) begin
      // On a tie, round-robin favours whichever port did not win last time.
      if (ROUND_ROBIN != 0) begin
        grant_port = (last_grant == ARB_PORT_I) ? ARB_PORT_D : ARB_PORT_I;
      end else begin
        grant_port = ARB_PORT_D;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one memory port and returns fill data.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ARB_IDLE | no transaction; grant the next requester and load mem_* regs
//   ARB_BUSY | mem_request high, mem_* held; wait for mem_finish
//   ARB_DONE | one gap cycle after completion so req/finish can drop
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,

  input  logic         i_req,
  input  logic [15:0]  i_addr,
  output logic         i_done,
  output logic [127:0] i_data,

  input  logic         d_req,
  input  logic         d_rwn,
  input  logic [15:0]  d_addr,
  input  logic [15:0]  d_commit,
  input  logic [127:0] d_wdata,
  output logic         d_done,
  output logic [127:0] d_rdata,

  output logic         mem_request,
  output logic         mem_rwn,
  output logic [15:0]  mem_addr,
  output logic [15:0]  mem_commit,
  output logic [127:0] mem_write_data,
  input  logic         mem_finish,
  input  logic         mem_replace,
  input  logic [127:0] mem_replace_dat
);

  arb_state_t          state;
  arb_port_t           owner;
  arb_port_t           last_grant;
  logic                grant_valid;
  logic                grant_raw;
  arb_port_t           grant_port;
  logic [MEM_LINE_W-1:0] line_q;

  mem_arb_pick #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_port  (grant_raw)
  );

  assign grant_port = arb_port_t'(grant_raw);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= ARB_IDLE;
      owner          <= ARB_PORT_I;
      last_grant     <= ARB_PORT_I;
      mem_request    <= 1'b0;
      mem_rwn        <= 1'b1;
      mem_addr       <= '0;
      mem_commit     <= '0;
      mem_write_data <= '0;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
      line_q         <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner       <= grant_port;
            last_grant  <= grant_port;
            mem_request <= 1'b1;
            if (grant_port == ARB_PORT_D) begin
              mem_rwn        <= d_rwn;
              mem_addr       <= line_align(d_addr);
              // A read carries no byte mask toward memory.
              mem_commit     <= d_rwn ? '0 : d_commit;
              mem_write_data <= d_wdata;
            end else begin
              mem_rwn        <= 1'b1;
              mem_addr       <= line_align(i_addr);
              mem_commit     <= '0;
              mem_write_data <= '0;
            end
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem_finish) begin
            mem_request <= 1'b0;
            if (mem_replace) begin
              line_q <= mem_replace_dat;
            end
            i_done <= (owner == ARB_PORT_I);
            d_done <= (owner == ARB_PORT_D);
            state  <= ARB_DONE;
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  assign i_data  = line_q;
  assign d_rdata = line_q;

endmodule
